memcmp_engine: RTL and testbench
================================

MEMCMP_ENGINE -- requirements
Module: memcmp_engine

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, byte width; ADDR_WIDTH, 8, memory address width.
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request pulse.
REQ-005 s1  input  ADDR_WIDTH  base address of region A.
REQ-006 s2  input  ADDR_WIDTH  base address of region B.
REQ-007 num  input  8  byte count.
REQ-008 busy  output  1  comparison in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result  output  DATA_WIDTH+1 (signed)  A[j]-B[j] at first mismatch j; 0 if all bytes are equal.
REQ-011 mismatch_idx  output  8  index j of first mismatch; num if all bytes are equal.
REQ-012 mem_oe  output  1  read enable to the single-port RAM.
REQ-013 mem_we  output  1  write enable to the RAM; SHALL be constant 0.
REQ-014 mem_addr  output  ADDR_WIDTH  RAM address.
REQ-015 mem_rd_q  input  DATA_WIDTH  registered RAM read data; valid one cycle after an oe cycle, Z otherwise.

Function
REQ-016 The FSM SHALL have states IDLE, RD_A, RD_B, CMP and FIN.
REQ-017 IDLE: on start=1, latch s1/s2/num, clear index i to 0, go to RD_A; if num=0, go to FIN instead.
REQ-018 RD_A: mem_addr=s1+i, mem_oe=1; next state RD_B.
REQ-019 RD_B: mem_addr=s2+i, mem_oe=1; capture mem_rd_q into byte_a at the clock edge; next state CMP.
REQ-020 CMP: mem_oe=0; compare byte_a with mem_rd_q.
REQ-021 CMP on mismatch: result=byte_a-byte_b (both zero-extended to 9 bits, signed difference); mismatch_idx=i; go to FIN.
REQ-022 CMP on match with i=num-1: result=0; mismatch_idx=num; go to FIN.
REQ-023 CMP otherwise: i<=i+1; go to RD_A.
REQ-024 FIN: done=1 for exactly one cycle; go to IDLE.
REQ-025 busy SHALL be 1 in RD_A, RD_B and CMP, and 0 in IDLE and FIN.
REQ-026 mem_addr SHALL be 0 whenever mem_oe=0.
REQ-027 mem_rd_q SHALL be sampled only in the cycle after an oe=1 cycle.
REQ-028 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH (s1=0xFF, i=1 -> address 0x00).
REQ-029 Latency: with start sampled at edge k, done SHALL be high in cycle k+3(j+1)+1, where j is the mismatch index or num-1 if all bytes match.
REQ-030 For num=0, done SHALL be high in cycle k+1, with no memory access.
REQ-031 start while busy or in FIN SHALL be ignored; latched operands SHALL be unaffected.
REQ-032 result and mismatch_idx SHALL hold their value until the next accepted start.
REQ-033 Throughput: 3 cycles per byte; 255 bytes equal -> done 766 cycles after start.

Reset
REQ-034 rst_n=0 SHALL immediately, without waiting for clk, force: IDLE; busy=0; done=0; mem_oe=0; mem_we=0; mem_addr=0; result=0; mismatch_idx=0; i=0.
REQ-035 Reset mid-operation SHALL abort the comparison with no done pulse.
REQ-036 The first start accepted after reset release SHALL behave normally.

Structure
REQ-037 ADDR_WIDTH/DATA_WIDTH defaults and the FSM state encodings SHALL live in the shared libc_hdl package/header, shared with memcpy.
REQ-038 The block SHALL be a single module with no sub-module.
REQ-039 The bench SHALL connect the engine to the existing single-port RAM, using that RAM's 1-cycle registered read.

Verification
REQ-040 RAM A[0x10..0x13]=B[0x40..0x43]={1,2,3,4}; start s1=0x10 s2=0x40 num=4 -> done at cycle 13; result=0; mismatch_idx=4.
REQ-041 Same data but B[0x42]=0x05 -> done at cycle 10; result=-2; mismatch_idx=2.
REQ-042 A[0]=0xFF, B[0]=0x00, num=1 -> result=+255, done at cycle 4; A[0]=0x00, B[0]=0xFF -> result=-255.
REQ-043 num=0 -> done at cycle 1, busy never 1, mem_oe never 1.
REQ-044 s1=0xFE, num=4, equal data -> mem_addr sequence for A is FE, FF, 00, 01; result=0.
REQ-045 Assert rst_n low during RD_B of byte 2 -> all outputs 0 asynchronously, no done pulse. Also: a second start issued while busy -> ignored, original result unchanged.

Source files
------------

// File: rtl/libc_hdl_pkg.sv
// Shared defaults and FSM encodings for the libc-style memory engines (memcmp, memcpy).
package libc_hdl_pkg;

  localparam int LIBC_DATA_WIDTH = 8;
  localparam int LIBC_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    CMP_IDLE = 3'd0,
    CMP_RD_A = 3'd1,
    CMP_RD_B = 3'd2,
    CMP_CMP  = 3'd3,
    CMP_FIN  = 3'd4
  } memcmp_state_t;

endpackage

// File: rtl/memcmp_engine.sv
// Byte-wise memcmp over a single-port RAM with registered read; 3 cycles per byte,
// done one cycle after the deciding compare. start is ignored unless idle.
module memcmp_engine
  import libc_hdl_pkg::*;
#(
  parameter int DATA_WIDTH = LIBC_DATA_WIDTH,
  parameter int ADDR_WIDTH = LIBC_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic        [ADDR_WIDTH-1:0] s1,
  input  logic        [ADDR_WIDTH-1:0] s2,
  input  logic        [7:0]            num,
  output logic                         busy,
  output logic                         done,
  output logic signed [DATA_WIDTH:0]   result,
  output logic        [7:0]            mismatch_idx,
  output logic                         mem_oe,
  output logic                         mem_we,
  output logic        [ADDR_WIDTH-1:0] mem_addr,
  input  logic        [DATA_WIDTH-1:0] mem_rd_q
);

  memcmp_state_t         state, state_nxt;
  logic [ADDR_WIDTH-1:0] a_base, b_base;
  logic [7:0]            num_r;
  logic [7:0]            idx;
  logic [DATA_WIDTH-1:0] byte_a;
  logic [DATA_WIDTH:0]   diff;
  logic                  is_diff;
  logic                  is_last;

  // Zero-extended subtraction yields the signed A-B difference directly.
  assign diff    = {1'b0, byte_a} - {1'b0, mem_rd_q};
  assign is_diff = (byte_a != mem_rd_q);
  assign is_last = (idx == num_r - 8'd1);
  assign mem_we  = 1'b0;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_oe    = 1'b0;
    mem_addr  = '0;
    case (state)
      CMP_IDLE: begin
        if (start) state_nxt = (num == 8'd0) ? CMP_FIN : CMP_RD_A;
      end
      CMP_RD_A: begin
        busy      = 1'b1;
        mem_oe    = 1'b1;
        mem_addr  = a_base + ADDR_WIDTH'(idx);
        state_nxt = CMP_RD_B;
      end
      CMP_RD_B: begin
        busy      = 1'b1;
        mem_oe    = 1'b1;
        mem_addr  = b_base + ADDR_WIDTH'(idx);
        state_nxt = CMP_CMP;
      end
      CMP_CMP: begin
        busy      = 1'b1;
        state_nxt = (is_diff || is_last) ? CMP_FIN : CMP_RD_A;
      end
      CMP_FIN: begin
        done      = 1'b1;
        state_nxt = CMP_IDLE;
      end
      default: state_nxt = CMP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CMP_IDLE;
      a_base       <= '0;
      b_base       <= '0;
      num_r        <= '0;
      idx          <= '0;
      byte_a       <= '0;
      result       <= '0;
      mismatch_idx <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        CMP_IDLE: begin
          if (start) begin
            a_base <= s1;
            b_base <= s2;
            num_r  <= num;
            idx    <= '0;
            if (num == 8'd0) begin
              result       <= '0;
              mismatch_idx <= '0;
            end
          end
        end
        // Read data of the A access lands while the B address is on the bus.
        CMP_RD_B: byte_a <= mem_rd_q;
        CMP_CMP: begin
          if (is_diff) begin
            result       <= $signed(diff);
            mismatch_idx <= idx;
          end else if (is_last) begin
            result       <= '0;
            mismatch_idx <= num_r;
          end else begin
            idx <= idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memcmp_engine.sv
// Self-checking bench: engine wired to a 1-cycle registered-read RAM model, checked against a memcmp reference.
module tb_memcmp_engine;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        s1 = '0, s2 = '0, num = '0;
  logic              busy, done, mem_oe, mem_we;
  logic signed [8:0] result;
  logic [7:0]        mismatch_idx, mem_addr;
  wire  [7:0]        mem_rd_q;

  logic [7:0] ram [256];
  logic [7:0] ram_q = '0;
  logic       ram_vld = 1'b0;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0;
  bit busy_seen = 0, oe_seen = 0;
  logic [7:0] addr_q[$];

  memcmp_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s1(s1), .s2(s2), .num(num),
    .busy(busy), .done(done), .result(result), .mismatch_idx(mismatch_idx),
    .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_rd_q(mem_rd_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ram_vld <= mem_oe;
    if (mem_oe) ram_q <= ram[mem_addr];
  end
  assign mem_rd_q = ram_vld ? ram_q : 8'bz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_seen = 1;
    if (mem_oe === 1'b1) begin
      oe_seen = 1;
      addr_q.push_back(mem_addr);
    end
    chk("mem_we_zero", mem_we, 0);
    chk("addr_zero_when_idle", (mem_oe !== 1'b1 && mem_addr !== 8'd0) ? 1 : 0, 0);
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_oe"}, mem_oe, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_result"}, 32'($signed(result)), 0);
    chk({tag, "_idx"}, mismatch_idx, 0);
  endtask

  // Reference: plain memcmp over the RAM array, with 3 cycles per byte visited.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n, input bit disturb);
    int exp_res, exp_idx, exp_lat, visited, k, w, d0;
    logic [7:0] exp_addr[$];
    exp_res = 0;
    exp_idx = int'(n);
    visited = int'(n);
    for (int j = 0; j < int'(n); j++) begin
      if (ram[8'(a + j)] != ram[8'(b + j)]) begin
        exp_res = int'(ram[8'(a + j)]) - int'(ram[8'(b + j)]);
        exp_idx = j;
        visited = j + 1;
        break;
      end
    end
    for (int j = 0; j < visited; j++) begin
      exp_addr.push_back(8'(a + j));
      exp_addr.push_back(8'(b + j));
    end
    exp_lat = (n == 0) ? 1 : 3 * visited + 1;

    @(negedge clk);
    addr_q.delete();
    busy_seen = 0;
    oe_seen = 0;
    d0 = done_cnt;
    s1 = a; s2 = b; num = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = cyc;
    w = 0;
    while (done !== 1'b1 && w < 1000) begin
      if (disturb && w == 2) begin
        s1 = ~a; s2 = ~b; num = 8'd7; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      w++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("latency", cyc - k + 1, exp_lat);
    chk("result", 32'($signed(result)), exp_res);
    chk("mismatch_idx", mismatch_idx, exp_idx);
    if (disturb) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("busy_after_fin", busy, 0);
    chk("done_count", done_cnt - d0, 1);
    chk("busy_seen", busy_seen, (n != 0) ? 1 : 0);
    chk("oe_seen", oe_seen, (n != 0) ? 1 : 0);
    chk("addr_count", addr_q.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < addr_q.size(); i++)
      chk("addr_seq", addr_q[i], exp_addr[i]);
    repeat (2) @(negedge clk);
    chk("result_hold", 32'($signed(result)), exp_res);
    chk("idx_hold", mismatch_idx, exp_idx);
  endtask

  initial begin
    int d0;
    logic [7:0] a, b, n;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);

    #2;
    chk_all_zero("reset_async");
    chk("reset_we", mem_we, 0);
    repeat (3) @(negedge clk);
    chk_all_zero("reset_held");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      ram[8'h10 + i] = 8'(i + 1);
      ram[8'h40 + i] = 8'(i + 1);
    end
    run_op(8'h10, 8'h40, 8'd4, 0);
    ram[8'h42] = 8'h05;
    run_op(8'h10, 8'h40, 8'd4, 0);

    ram[8'h80] = 8'hFF; ram[8'h90] = 8'h00;
    run_op(8'h80, 8'h90, 8'd1, 0);
    ram[8'h80] = 8'h00; ram[8'h90] = 8'hFF;
    run_op(8'h80, 8'h90, 8'd1, 0);

    run_op(8'h22, 8'h33, 8'd0, 0);

    for (int i = 0; i < 4; i++) begin
      ram[8'(8'hFE + i)] = 8'(8'hA0 + i);
      ram[8'h60 + i]     = 8'(8'hA0 + i);
    end
    run_op(8'hFE, 8'h60, 8'd4, 0);

    ram[8'h42] = 8'h05;
    run_op(8'h10, 8'h40, 8'd4, 1);

    // Abort during RD_B of byte 2 of an equal-data compare.
    ram[8'h42] = 8'h03;
    @(negedge clk);
    d0 = done_cnt;
    s1 = 8'h10; s2 = 8'h40; num = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    chk("pre_abort_addr", mem_addr, 8'h42);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("abort_async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    run_op(8'h10, 8'h40, 8'd4, 0);

    for (int i = 0; i < 256; i++) ram[i] = 8'h5A;
    run_op(8'h00, 8'h80, 8'd255, 0);

    for (int t = 0; t < 25; t++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      n = 8'($urandom_range(0, 24));
      for (int j = 0; j < int'(n); j++) ram[8'(a + j)] = 8'($urandom);
      for (int j = 0; j < int'(n); j++) ram[8'(b + j)] = ram[8'(a + j)];
      if (n != 0 && $urandom_range(0, 2) != 0)
        ram[8'(b + $urandom_range(0, int'(n) - 1))] = 8'($urandom);
      run_op(a, b, n, (n >= 3) && ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
